// File: rtl/kgp_mem_pkg.sv
// Shared definitions for the data-memory access unit: FSM encoding, word width
// and the address legality check used at request accept.
package kgp_mem_pkg;

  localparam int WORD_W          = 32;
  localparam int DMEM_ADDR_W_DEF = 10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  // Misaligned, or any bit set above the word-addressable range of the memory.
  function automatic logic addr_err(input logic [WORD_W-1:0] addr, input int aw);
    return (addr[1:0] != 2'b00) || ((addr >> (aw + 2)) != {WORD_W{1'b0}});
  endfunction

endpackage

// File: rtl/mem_access_unit.sv
// Single-outstanding load/store front end for a synchronous data memory with a
// fixed read latency; misaligned or out-of-range requests are answered directly.
module mem_access_unit
  import kgp_mem_pkg::*;
#(
  parameter int DMEM_ADDR_W = DMEM_ADDR_W_DEF,
  parameter int RD_LATENCY  = 1
) (
  input  logic                   clka,
  input  logic                   rst_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_we,
  input  logic [WORD_W-1:0]      req_addr,
  input  logic [WORD_W-1:0]      req_wdata,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [WORD_W-1:0]      rsp_rdata,
  output logic                   rsp_err,
  output logic                   ram_ena,
  output logic                   ram_wea,
  output logic [DMEM_ADDR_W-1:0] ram_addra,
  output logic [WORD_W-1:0]      ram_dina,
  input  logic [WORD_W-1:0]      ram_douta
);

  localparam logic [2:0] WAIT_LAST = 3'(RD_LATENCY - 1);
  localparam logic [2:0] WAIT_MAX  = 3'd7;

  state_t                 state_r;
  state_t                 state_n;
  logic [2:0]             wait_cnt_r;
  logic                   ram_ena_r;
  logic                   ram_wea_r;
  logic [DMEM_ADDR_W-1:0] ram_addra_r;
  logic [WORD_W-1:0]      ram_dina_r;
  logic                   rsp_valid_r;
  logic [WORD_W-1:0]      rsp_rdata_r;
  logic                   rsp_err_r;
  logic                   accept_s;
  logic                   req_err_s;
  logic                   last_wait_s;

  assign req_ready   = (state_r == ST_IDLE);
  assign accept_s    = req_valid && req_ready;
  assign req_err_s   = addr_err(req_addr, DMEM_ADDR_W);
  assign last_wait_s = (wait_cnt_r == WAIT_LAST);

  assign ram_ena   = ram_ena_r;
  assign ram_wea   = ram_wea_r;
  assign ram_addra = ram_addra_r;
  assign ram_dina  = ram_dina_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_rdata = rsp_rdata_r;
  assign rsp_err   = rsp_err_r;

  // State register.
  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_n;
    end
  end

  // Next-state decode.
  always_comb begin
    state_n = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_n = req_err_s ? ST_RESP : ST_ACCESS;
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        // ram_wea_r still carries the registered req_we during ACCESS.
        state_n = ram_wea_r ? ST_RESP : ST_WAIT;
      end
      ST_WAIT: begin
        if (last_wait_s) begin
          state_n = ST_RESP;
        end else begin
          state_n = ST_WAIT;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_n = ST_IDLE;
        end else begin
          state_n = ST_RESP;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Memory port, wait counter and response registers.
  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_r  <= 3'd0;
      ram_ena_r   <= 1'b0;
      ram_wea_r   <= 1'b0;
      ram_addra_r <= {DMEM_ADDR_W{1'b0}};
      ram_dina_r  <= {WORD_W{1'b0}};
      rsp_valid_r <= 1'b0;
      rsp_rdata_r <= {WORD_W{1'b0}};
      rsp_err_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s && req_err_s) begin
            rsp_valid_r <= 1'b1;
            rsp_err_r   <= 1'b1;
            rsp_rdata_r <= {WORD_W{1'b0}};
          end else if (accept_s) begin
            ram_ena_r   <= 1'b1;
            ram_wea_r   <= req_we;
            ram_addra_r <= req_addr[DMEM_ADDR_W+1:2];
            ram_dina_r  <= req_wdata;
          end
        end
        ST_ACCESS: begin
          ram_ena_r  <= 1'b0;
          ram_wea_r  <= 1'b0;
          wait_cnt_r <= 3'd0;
          if (ram_wea_r) begin
            rsp_valid_r <= 1'b1;
            rsp_err_r   <= 1'b0;
            rsp_rdata_r <= {WORD_W{1'b0}};
          end
        end
        ST_WAIT: begin
          if (last_wait_s) begin
            wait_cnt_r  <= 3'd0;
            rsp_valid_r <= 1'b1;
            rsp_err_r   <= 1'b0;
            rsp_rdata_r <= ram_douta;
          end else if (wait_cnt_r != WAIT_MAX) begin
            wait_cnt_r <= wait_cnt_r + 3'd1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid_r <= 1'b0;
            rsp_err_r   <= 1'b0;
            rsp_rdata_r <= {WORD_W{1'b0}};
          end
        end
        default: begin
          ram_ena_r   <= 1'b0;
          ram_wea_r   <= 1'b0;
          rsp_valid_r <= 1'b0;
          wait_cnt_r  <= 3'd0;
        end
      endcase
    end
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter: DMEM_ADDR_W, default 10, word-address width of the data memory port.
REQ-002 Parameter: RD_LATENCY, default 1, data memory read latency in clock edges; legal range 1..4.
REQ-003 Clocking: one clock, clka; reset rst_n is asynchronous and active-low.
REQ-004 Port: clka  in  1  clock; all state changes on the rising edge.
REQ-005 Port: rst_n  in  1  asynchronous active-low reset.
REQ-006 Port: req_valid  in  1  access request present.
REQ-007 Port: req_ready  out  1  unit can accept a request.
REQ-008 Port: req_we  in  1  1 = store, 0 = load.
REQ-009 Port: req_addr  in  32  byte address.
REQ-010 Port: req_wdata  in  32  store data.
REQ-011 Port: rsp_valid  out  1  response present.
REQ-012 Port: rsp_ready  in  1  consumer accepts the response.
REQ-013 Port: rsp_rdata  out  32  load data; 0 for stores and errors.
REQ-014 Port: rsp_err  out  1  request was misaligned or out of range.
REQ-015 Port: ram_ena  out  1  data memory enable.
REQ-016 Port: ram_wea  out  1  data memory write enable.
REQ-017 Port: ram_addra  out  DMEM_ADDR_W  data memory word address.
REQ-018 Port: ram_dina  out  32  data memory write data.
REQ-019 Port: ram_douta  in  32  data memory read data.

Function
REQ-020 The FSM SHALL have the states IDLE, ACCESS, WAIT and RESP.
REQ-021 req_ready SHALL be 1 only in IDLE, decoded combinationally from the state; at most one request is outstanding.
REQ-022 A request is accepted at a rising edge where req_valid and req_ready are both 1, and the unit SHALL register req_we, req_addr and req_wdata at that edge.
REQ-023 An accepted request SHALL be flagged as an error if req_addr[1:0] != 0 or req_addr[31:DMEM_ADDR_W+2] != 0.
REQ-024 Error path: IDLE -> RESP with rsp_err=1 and rsp_rdata=0; ram_ena SHALL NOT assert; rsp_valid rises 1 cycle after accept.
REQ-025 Valid path: IDLE -> ACCESS, with ram_addra = req_addr[DMEM_ADDR_W+1:2] and ram_dina = req_wdata.
REQ-026 ram_ena SHALL be 1 exactly during the single ACCESS cycle; ram_wea SHALL equal the registered req_we in ACCESS and SHALL be 0 in every other state.
REQ-027 Store: ACCESS -> RESP with rsp_rdata=0 and rsp_err=0; rsp_valid rises 2 cycles after accept.
REQ-028 Load: ACCESS -> WAIT; WAIT SHALL last exactly RD_LATENCY cycles, counted by a saturating counter.
REQ-029 Load: at the final WAIT edge, rsp_rdata SHALL capture ram_douta and the FSM SHALL enter RESP; rsp_valid rises RD_LATENCY+2 cycles after accept (3 at default).
REQ-030 In RESP, rsp_valid, rsp_rdata and rsp_err SHALL hold stable until an edge with rsp_ready=1, which SHALL move the FSM to IDLE.
REQ-031 A new request SHALL NOT be accepted in the same cycle as a response handshake; the earliest next accept is the following edge.
REQ-032 Outside ACCESS, ram_addra and ram_dina SHALL hold their last values.
REQ-033 rsp_valid SHALL be 0 in IDLE, ACCESS and WAIT.

Reset
REQ-034 While rst_n=0, asynchronously: state=IDLE, wait counter=0, ram_ena=0, ram_wea=0, ram_addra=0, ram_dina=0, rsp_valid=0, rsp_rdata=0, rsp_err=0.
REQ-035 Reset asserted in ACCESS SHALL deassert ram_ena/ram_wea before the next edge, so the in-flight write is dropped; an in-flight load or response is discarded.
REQ-036 After rst_n deasserts, req_ready SHALL be 1 at the first edge.

Structure
REQ-037 The shared package/header kgp_mem_pkg SHALL hold the state encodings (IDLE=0, ACCESS=1, WAIT=2, RESP=3), WORD_W=32 and the default DMEM_ADDR_W=10.
REQ-038 No sub-module is required; the RD_LATENCY counter SHALL be inline.
REQ-039 The block SHALL connect directly to the existing Data_Memory port (clka, ena, wea, addra, dina, douta) with no glue logic.

Verification (bench instantiates Data_Memory, RD_LATENCY=1)
REQ-040 Store req_addr=0x8, req_wdata=32 -> ram_addra=2, ram_wea=1, ram_dina=32 for exactly one cycle; rsp_valid 2 cycles after accept; rsp_err=0.
REQ-041 Load req_addr=0x8 following the store -> ram_wea=0; rsp_rdata=32 with rsp_valid 3 cycles after accept.
REQ-042 Load req_addr=0x6, then load req_addr=0x1000 -> each gives rsp_err=1 and rsp_rdata=0 one cycle after accept; ram_ena stays 0.
REQ-043 Load 0x8 with rsp_ready=0 for 4 cycles -> rsp_valid=1 and rsp_rdata=32 held; req_ready=0; IDLE on the edge after rsp_ready=1.
REQ-044 Store 0xDEAD to 0x10 with rst_n pulsed low mid-ACCESS -> ram_wea drops immediately; a later load of 0x10 returns 0.
REQ-045 Back-to-back requests with req_valid held at 1 and rsp_ready=1 -> every accept is separated by at least one idle edge, and no request is lost or duplicated.
